hb_interp: RTL and testbench

HB_INTERP -- requirements
Module: hb_interp

---
 rtl/hb_interp.sv | 210 +++++++++++++++++++++
 tb/tb_hb_interp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_interp.sv
// -----------------------------------------------------------------------------
// hb_interp
// 2x half-band interpolating FIR. Each accepted input sample produces two
// output samples: phase A (the symmetric-pair sum) and phase B (the centre tap).
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous, active-high reset
//   in_valid    input sample valid
//   in_ready    block accepts a sample this cycle
//   in_sample   input sample x[n], unsigned
//   coeff       tap array h[0..FILTER_ORDER-1], held static during operation
//   out_valid   output sample valid
//   out_ready   downstream accepts output
//   out_sample  interpolated sample y, zero-extended
//   out_phase   0 = phase A (even output), 1 = phase B (odd output)
// -----------------------------------------------------------------------------
module hb_interp #(
    parameter int INPUT_SAMPLE_DATA_WIDTH  = 8,
    parameter int COEFF_DATA_WIDTH         = 10,
    parameter int FILTER_ORDER             = 15,
    parameter int OUTPUT_SAMPLE_DATA_WIDTH = 22
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [INPUT_SAMPLE_DATA_WIDTH-1:0]                  in_sample,
    input  logic [FILTER_ORDER-1:0][COEFF_DATA_WIDTH-1:0]       coeff,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [OUTPUT_SAMPLE_DATA_WIDTH-1:0]                 out_sample,
    output logic                                                out_phase
);

    localparam int IW     = INPUT_SAMPLE_DATA_WIDTH;
    localparam int CW     = COEFF_DATA_WIDTH;
    localparam int OW     = OUTPUT_SAMPLE_DATA_WIDTH;
    localparam int TAPS   = (FILTER_ORDER + 1) / 2;   // delay line length
    localparam int PAIRS  = TAPS / 2;                 // symmetric pairs
    localparam int MID    = FILTER_ORDER / 2;         // centre tap index
    localparam int PRE_W  = IW + 1;
    localparam int MUL_W  = PRE_W + CW;
    localparam int PAIR_W = MUL_W + 1;
    localparam int FIN_W  = PAIR_W + 1;
    localparam int B_W    = IW + CW;

    typedef enum logic [1:0] {EMPTY, SEND_A, SEND_B} state_t;

    logic [FILTER_ORDER-1:0][CW-1:0] coeff_q;
    logic                            unused_coeff_bits;

    logic [IW-1:0]     dl [TAPS];
    logic              dl_v;
    logic [PRE_W-1:0]  pre [PAIRS];
    logic [IW-1:0]     pre_x;
    logic              pre_v;
    logic [MUL_W-1:0]  mul [PAIRS];
    logic [B_W-1:0]    mul_b;
    logic              mul_v;
    logic [PAIR_W-1:0] pair_a [2];
    logic [B_W-1:0]    pair_b;
    logic              pair_v;
    logic [FIN_W-1:0]  fin_a;
    logic [B_W-1:0]    fin_b;
    logic              fin_v;

    logic              en;
    state_t            state;
    state_t            state_next;
    logic              load;
    logic [FIN_W-1:0]  a_q;
    logic [B_W-1:0]    b_q;

    // The half-band structure only needs the even taps of one half plus the
    // centre; the remaining registered bits are folded here so they are
    // visibly accounted for.
    always_comb begin
        unused_coeff_bits = 1'b0;
        for (int i = 0; i < FILTER_ORDER; i++) begin
            if (!(((i % 2) == 0 && i < 2 * PAIRS) || i == MID)) begin
                unused_coeff_bits = unused_coeff_bits ^ (^coeff_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_q <= '0;
        end else begin
            coeff_q <= coeff;
        end
    end

    // The pipeline stalls as a whole only when the head stage holds a result
    // the output FSM cannot take this cycle. Reset forces the enable high so
    // in_ready reads 1 while reset is held.
    assign en = rst || !(fin_v && !(state == EMPTY || (state == SEND_B && out_ready)));
    assign in_ready = en;

    // Delay line plus A datapath (pre-add, multiply, pair-add, final-add) and
    // the matched-delay B chain. dl_v marks a freshly accepted sample that the
    // pre-add stage has not yet consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) dl[i] <= '0;
            for (int k = 0; k < PAIRS; k++) begin
                pre[k] <= '0;
                mul[k] <= '0;
            end
            pair_a[0] <= '0;
            pair_a[1] <= '0;
            dl_v   <= 1'b0;
            pre_x  <= '0;
            pre_v  <= 1'b0;
            mul_b  <= '0;
            mul_v  <= 1'b0;
            pair_b <= '0;
            pair_v <= 1'b0;
            fin_a  <= '0;
            fin_b  <= '0;
            fin_v  <= 1'b0;
        end else if (en) begin
            if (in_valid) begin
                dl[0] <= in_sample;
                for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
            end
            dl_v <= in_valid;

            for (int k = 0; k < PAIRS; k++) begin
                pre[k] <= PRE_W'(dl[k]) + PRE_W'(dl[TAPS-1-k]);
            end
            pre_x <= dl[PAIRS-1];
            pre_v <= dl_v;

            for (int k = 0; k < PAIRS; k++) begin
                mul[k] <= MUL_W'(pre[k]) * MUL_W'(coeff_q[2*k]);
            end
            mul_b <= B_W'(pre_x) * B_W'(coeff_q[MID]);
            mul_v <= pre_v;

            pair_a[0] <= PAIR_W'(mul[0]) + PAIR_W'(mul[1]);
            pair_a[1] <= PAIR_W'(mul[2]) + PAIR_W'(mul[3]);
            pair_b    <= mul_b;
            pair_v    <= mul_v;

            fin_a <= FIN_W'(pair_a[0]) + FIN_W'(pair_a[1]);
            fin_b <= pair_b;
            fin_v <= pair_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                a_q <= fin_a;
                b_q <= fin_b;
            end
        end
    end

    // A pair is loaded exactly when the enable lets the head stage advance,
    // so nothing is lost or repeated. Outputs are forced idle while reset is
    // asserted.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        out_valid  = 1'b0;
        out_phase  = 1'b0;
        out_sample = '0;
        case (state)
            EMPTY: begin
                if (fin_v) begin
                    load       = 1'b1;
                    state_next = SEND_A;
                end
            end
            SEND_A: begin
                out_valid  = 1'b1;
                out_sample = OW'(a_q);
                if (out_ready) state_next = SEND_B;
            end
            SEND_B: begin
                out_valid  = 1'b1;
                out_phase  = 1'b1;
                out_sample = OW'(b_q);
                if (out_ready) begin
                    if (fin_v) begin
                        load       = 1'b1;
                        state_next = SEND_A;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
        if (rst) begin
            out_valid  = 1'b0;
            out_phase  = 1'b0;
            out_sample = '0;
        end
    end

endmodule

// File: tb/tb_hb_interp.sv
// -----------------------------------------------------------------------------
// tb_hb_interp
// Directed self-checking bench for hb_interp: reset state, latency, impulse,
// DC, full-scale, backpressure, throughput and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_hb_interp;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_sample;
    logic [14:0][9:0]  coeff;
    logic              out_valid;
    logic              out_ready;
    logic [21:0]       out_sample;
    logic              out_phase;

    int compareCount;
    int failCount;

    logic [21:0] gotS[$];
    logic        gotP[$];
    logic [7:0]  stimVec[$];
    int          acceptCyc[64];

    int impA[8] = '{1, 2, 3, 4, 4, 3, 2, 1};

    hb_interp dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .coeff      (coeff),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_phase  (out_phase)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded loops
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, record acceptance and any output handshake,
    // then advance to the next falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] s, output logic acc);
        in_valid  = v;
        in_sample = s;
        #1;
        acc = in_valid && in_ready && !rst;
        if (out_valid && out_ready && !rst) begin
            gotS.push_back(out_sample);
            gotP.push_back(out_phase);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        logic acc;
        rst = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 8'd0, acc);
        applyStimulus(1'b0, 8'd0, acc);
        rst = 1'b0;
    endtask

    task automatic setImpulseCoeffs();
        coeff     = '0;
        coeff[0]  = 10'd1;  coeff[14] = 10'd1;
        coeff[2]  = 10'd2;  coeff[12] = 10'd2;
        coeff[4]  = 10'd3;  coeff[10] = 10'd3;
        coeff[6]  = 10'd4;  coeff[8]  = 10'd4;
        coeff[7]  = 10'd8;
    endtask

    task automatic loadImpulse(input logic [7:0] value);
        stimVec.delete();
        stimVec.push_back(value);
        for (int i = 1; i < 16; i++) stimVec.push_back(8'd0);
    endtask

    // Stream stimVec with in_valid held whenever samples remain, optionally
    // dropping out_ready for stallLen cycles starting at stallAt, and drain
    // until two outputs per input have been collected.
    task automatic runStream(input int stallAt, input int stallLen);
        int idx;
        int cyc;
        int n;
        logic acc;
        logic [21:0] holdS;
        logic holdP;
        n = stimVec.size();
        idx = 0;
        cyc = 0;
        holdS = '0;
        holdP = 1'b0;
        gotS.delete();
        gotP.delete();
        while ((idx < n || gotS.size() < 2 * n) && cyc < 600) begin
            out_ready = !(stallLen > 0 && cyc >= stallAt && cyc < stallAt + stallLen);
            in_valid  = (idx < n);
            in_sample = (idx < n) ? stimVec[idx] : 8'd0;
            #1;
            if (stallLen > 0 && cyc == stallAt) begin
                checkOutput("bp_valid_at_stall", {31'd0, out_valid}, 32'd1);
                holdS = out_sample;
                holdP = out_phase;
            end
            if (stallLen > 0 && cyc == stallAt + stallLen - 1) begin
                checkOutput("bp_sample_stable", {10'd0, out_sample}, {10'd0, holdS});
                checkOutput("bp_phase_stable", {31'd0, out_phase}, {31'd0, holdP});
                checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            end
            applyStimulus(in_valid, in_sample, acc);
            if (acc) begin
                acceptCyc[idx] = cyc;
                idx++;
            end
            cyc++;
        end
        if (cyc >= 600) checkOutput("stream_timeout", cyc, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic checkImpulse(input string prefix);
        int expA;
        int expB;
        checkOutput({prefix, "_count"}, gotS.size(), 32'd32);
        for (int k = 0; k < 16; k++) begin
            if (2 * k + 1 < gotS.size()) begin
                expA = (k < 8) ? impA[k] : 0;
                expB = (k == 3) ? 8 : 0;
                checkOutput($sformatf("%s_A%0d", prefix, k), {10'd0, gotS[2*k]}, expA);
                checkOutput($sformatf("%s_B%0d", prefix, k), {10'd0, gotS[2*k+1]}, expB);
                checkOutput($sformatf("%s_phA%0d", prefix, k), {31'd0, gotP[2*k]}, 32'd0);
                checkOutput($sformatf("%s_phB%0d", prefix, k), {31'd0, gotP[2*k+1]}, 32'd1);
            end
        end
    endtask

    task automatic checkPair(input string tag, input int k, input int expA, input int expB);
        if (2 * k + 1 < gotS.size()) begin
            checkOutput({tag, "_A"}, {10'd0, gotS[2*k]}, expA);
            checkOutput({tag, "_B"}, {10'd0, gotS[2*k+1]}, expB);
            checkOutput({tag, "_phA"}, {31'd0, gotP[2*k]}, 32'd0);
            checkOutput({tag, "_phB"}, {31'd0, gotP[2*k+1]}, 32'd1);
        end else begin
            checkOutput({tag, "_missing"}, gotS.size(), 2 * k + 2);
        end
    endtask

    initial begin
        logic acc;
        int lat;
        int cnt;
        compareCount = 0;
        failCount    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = 8'd0;
        out_ready = 1'b1;
        setImpulseCoeffs();
        @(negedge clk);

        // Reset state, during and on the cycle after reset
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        doReset();
        #1;
        checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("post_rst_out_sample", {10'd0, out_sample}, 32'd0);
        checkOutput("post_rst_out_phase", {31'd0, out_phase}, 32'd0);
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency: single accept at cycle 0, first out_valid at cycle 6
        gotS.delete();
        gotP.delete();
        applyStimulus(1'b1, 8'd1, acc);
        checkOutput("lat_accept", {31'd0, acc}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
            applyStimulus(1'b0, 8'd0, acc);
        end
        checkOutput("lat_cycles", lat, 32'd6);
        checkOutput("lat_first_A", {10'd0, out_sample}, 32'd1);
        checkOutput("lat_first_phase", {31'd0, out_phase}, 32'd0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'd0, acc);

        // Impulse response plus steady-state 1-in-2 acceptance
        doReset();
        loadImpulse(8'd1);
        runStream(0, 0);
        checkImpulse("imp");
        checkOutput("thr_gap", acceptCyc[8] - acceptCyc[7], 32'd2);
        checkOutput("thr_span", acceptCyc[15] - acceptCyc[7], 32'd16);

        // DC: constant 255
        doReset();
        stimVec.delete();
        for (int i = 0; i < 20; i++) stimVec.push_back(8'd255);
        runStream(0, 0);
        checkPair("dc7", 7, 5100, 2040);
        checkPair("dc19", 19, 5100, 2040);

        // Backpressure: 20 stalled cycles mid-stream, sequence must survive
        doReset();
        loadImpulse(8'd1);
        runStream(14, 20);
        checkImpulse("bp");

        // Mid-stream reset while presenting phase A
        doReset();
        loadImpulse(8'd1);
        cnt = 0;
        begin
            int idx;
            idx = 0;
            out_ready = 1'b1;
            while (cnt < 60) begin
                in_valid  = (idx < 16);
                in_sample = (idx < 16) ? stimVec[idx] : 8'd0;
                #1;
                if (out_valid && !out_phase && out_sample == 22'd3) break;
                applyStimulus(in_valid, in_sample, acc);
                if (acc) idx++;
                cnt++;
            end
        end
        checkOutput("mrst_reached_A", (cnt < 60) ? 32'd1 : 32'd0, 32'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("mrst_during_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mrst_during_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b0, 8'd0, acc);
        rst = 1'b0;
        #1;
        checkOutput("mrst_after_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mrst_after_sample", {10'd0, out_sample}, 32'd0);
        runStream(0, 0);
        checkImpulse("mrst");

        // Full scale: every tap 1023, x = 255
        coeff = '1;
        doReset();
        stimVec.delete();
        for (int i = 0; i < 12; i++) stimVec.push_back(8'd255);
        runStream(0, 0);
        checkPair("fs11", 11, 2086920, 260865);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
